// File: rtl/masked_affine_pipe.sv
// masked_affine_pipe: share-wise 4-bit affine map with optional remasking, followed by a
// valid/ready register pipeline that carries the mode along with the data.
module masked_affine_pipe #(
  parameter int SHARES = 2,
  parameter int NIBBLES = 1,
  parameter int PIPE = 1,
  parameter int REFRESH = 1,
  parameter logic [15:0] M0 = 16'h8421,
  parameter logic [3:0] C0 = 4'h0,
  parameter logic [15:0] M1 = 16'h8421,
  parameter logic [3:0] C1 = 4'hF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_mode,
  input  logic [SHARES*NIBBLES*4-1:0] in_data,
  input  logic [(SHARES-1)*NIBBLES*4-1:0] in_rnd,
  output logic out_valid,
  input  logic out_ready,
  output logic [SHARES*NIBBLES*4-1:0] out_data
);
  localparam int LW = NIBBLES*4;
  localparam int W = SHARES*LW;
  logic [PIPE-1:0] v, ok, pv;
  logic m [PIPE];
  logic pm [PIPE];
  logic [W-1:0] d [PIPE];
  logic [W-1:0] pd [PIPE];
  logic [W-1:0] aff, rs;
  logic [LW-1:0] rall;
  function automatic logic [3:0] mul(input logic [15:0] mat, input logic [3:0] x);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) y[i] = ^(mat[4*i +: 4] & x);
    return y;
  endfunction
  // Share 0 absorbs the XOR of all fresh masks so the unshared value is unchanged.
  always_comb begin
    rall = '0;
    for (int s = 1; s < SHARES; s++) rall ^= in_rnd[(s-1)*LW +: LW];
    rs = {in_rnd, rall};
    aff = '0;
    for (int s = 0; s < SHARES; s++)
      for (int n = 0; n < NIBBLES; n++)
        aff[s*LW + n*4 +: 4] = mul(in_mode ? M1 : M0, in_data[s*LW + n*4 +: 4])
          ^ (s == 0 ? (in_mode ? C1 : C0) : 4'h0)
          ^ (REFRESH != 0 ? rs[s*LW + n*4 +: 4] : 4'h0);
  end
  // A stage may load when out_ready is high or any stage at or after it is empty.
  always_comb begin
    for (int k = 0; k < PIPE; k++)
      ok[k] = out_ready || ((v >> k) != ({PIPE{1'b1}} >> k));
    pv[0] = in_valid;
    pm[0] = in_mode;
    pd[0] = aff;
    for (int k = 1; k < PIPE; k++) begin
      pv[k] = v[k-1];
      pm[k] = m[k-1];
      pd[k] = d[k-1];
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < PIPE; k++) begin
        m[k] <= 1'b0;
        d[k] <= '0;
      end
    end else
      for (int k = 0; k < PIPE; k++)
        if (ok[k]) begin
          v[k] <= pv[k];
          if (pv[k]) begin
            m[k] <= pm[k];
            d[k] <= pd[k];
          end
        end
  assign in_ready = ok[0];
  assign out_valid = v[PIPE-1];
  assign out_data = d[PIPE-1];
endmodule

// File: tb/tb_masked_affine_pipe.sv
// tb_masked_affine_pipe: directed vectors on two small instances plus a scoreboarded
// random run on a 3-share, 4-nibble, 3-stage instance with a non-identity matrix.
module tb_masked_affine_pipe;
  localparam logic [15:0] BM0 = 16'h3A5C;
  localparam logic [3:0] BC0 = 4'h7;
  localparam logic [15:0] BM1 = 16'hF1E2;
  localparam logic [3:0] BC1 = 4'hB;
  typedef struct {logic [47:0] d; logic [15:0] u;} exp_t;
  logic clk = 0, rst_n = 0;
  logic iv_s = 0, md_s = 0, ordy_s = 0;
  logic [7:0] id_s = '0;
  logic [3:0] rn_s = '0;
  logic ir0, ov0, ir1, ov1;
  logic [7:0] od0, od1;
  logic iv_b = 0, md_b = 0, ordy_b = 0, ir_b, ov_b;
  logic [47:0] id_b = '0, od_b, held = '0;
  logic [31:0] rn_b = '0;
  int n_chk = 0, n_err = 0, cyc = 0, acc_cyc = 0, out_cyc = 0, nin = 0, n0;
  logic ir_seen = 0, stalled = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  masked_affine_pipe #(.REFRESH(0)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir0),
    .in_mode(md_s), .in_data(id_s), .in_rnd(rn_s), .out_valid(ov0), .out_ready(ordy_s), .out_data(od0));
  masked_affine_pipe #(.REFRESH(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir1),
    .in_mode(md_s), .in_data(id_s), .in_rnd(rn_s), .out_valid(ov1), .out_ready(ordy_s), .out_data(od1));
  masked_affine_pipe #(.SHARES(3), .NIBBLES(4), .PIPE(3), .REFRESH(1), .M0(BM0), .C0(BC0), .M1(BM1), .C1(BC1)) ub (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_mode(md_b), .in_data(id_b),
    .in_rnd(rn_b), .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Column view of the matrix: column j = {M[12+j], M[8+j], M[4+j], M[j]}.
  function automatic logic [3:0] mul(input logic [15:0] mat, input logic [3:0] x);
    logic [3:0] y = '0;
    for (int j = 0; j < 4; j++)
      if (x[j]) y ^= {mat[12+j], mat[8+j], mat[4+j], mat[j]};
    return y;
  endfunction
  function automatic exp_t model(input logic md, input logic [47:0] x, input logic [31:0] r);
    exp_t e;
    logic [15:0] mm = md ? BM1 : BM0;
    logic [3:0] c = md ? BC1 : BC0;
    logic [3:0] rsum, xa, xs, y;
    e.d = '0;
    e.u = '0;
    for (int n = 0; n < 4; n++) begin
      rsum = r[n*4 +: 4] ^ r[16+n*4 +: 4];
      xa = '0;
      for (int s = 0; s < 3; s++) begin
        xs = x[s*16+n*4 +: 4];
        xa ^= xs;
        if (s == 0) y = mul(mm, xs) ^ c ^ rsum;
        else y = mul(mm, xs) ^ r[(s-1)*16+n*4 +: 4];
        e.d[s*16+n*4 +: 4] = y;
      end
      e.u[n*4 +: 4] = mul(mm, xa) ^ c;
    end
    return e;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic iv, input logic ordy);
    iv_b = iv;
    ordy_b = ordy;
    md_b = 1'($urandom());
    id_b = 48'({$urandom(), $urandom()});
    rn_b = $urandom();
    @(negedge clk);
    ir_seen = ir_b;
    if (stalled) chk("hold", od_b, held);
    if (ov_b) begin
      if (q.size() == 0) chk("spurious out_valid", ov_b, 1'b0);
      else begin
        chk("data", od_b, q[0].d);
        chk("unshared", od_b[15:0] ^ od_b[31:16] ^ od_b[47:32], q[0].u);
      end
    end
    if (ov_b && ordy && q.size() > 0) begin
      void'(q.pop_front());
      out_cyc = cyc;
    end
    if (iv && ir_b) begin
      q.push_back(model(md_b, id_b, rn_b));
      acc_cyc = cyc;
      nin++;
    end
    stalled = ov_b && !ordy;
    held = od_b;
    tick();
    cyc++;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk("rst ov0", ov0, 0); chk("rst od0", od0, 0); chk("rst ir0", ir0, 1);
    chk("rst ov1", ov1, 0); chk("rst od1", od1, 0); chk("rst ir1", ir1, 1);
    chk("rst ovb", ov_b, 0); chk("rst odb", od_b, 0); chk("rst irb", ir_b, 1);
    iv_s = 1; id_s = 8'h35; rn_s = 4'h6; md_s = 0; ordy_s = 1;
    tick();
    iv_s = 0;
    chk("m0 ov", ov0, 1); chk("m0 plain", od0, 8'h35); chk("m0 refresh", od1, 8'h53);
    chk("m0 refresh unshared", od1[7:4] ^ od1[3:0], 4'h6);
    tick();
    chk("one-cycle valid", ov0, 0);
    iv_s = 1; md_s = 1;
    tick();
    iv_s = 0;
    chk("m1 plain", od0, 8'h3A); chk("m1 unshared", od0[7:4] ^ od0[3:0], 4'h9);
    chk("m1 refresh", od1, 8'h5C); chk("m1 refresh unshared", od1[7:4] ^ od1[3:0], 4'h9);
    tick();
    step(1, 1);
    for (int i = 0; i < 8; i++) step(0, 1);
    chk("latency", out_cyc - acc_cyc, 3);
    n0 = nin;
    for (int i = 0; i < 10; i++) step(1, 1);
    chk("throughput", nin - n0, 10);
    for (int i = 0; i < 6; i++) step(0, 1);
    chk("drain1", q.size(), 0);
    for (int i = 0; i < 3; i++) step(1, 0);
    step(1, 0);
    chk("full in_ready", ir_seen, 0);
    chk("full count", q.size(), 3);
    step(1, 1);
    chk("swap in_ready", ir_seen, 1);
    chk("swap count", q.size(), 3);
    step(0, 0);
    for (int i = 0; i < 6; i++) step(0, 1);
    chk("drain2", q.size(), 0);
    for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6);
    for (int i = 0; i < 8; i++) step(0, 1);
    chk("drain3", q.size(), 0);
    step(1, 0);
    step(1, 0);
    rst_n = 0;
    iv_b = 0;
    tick();
    rst_n = 1;
    chk("midrst ov", ov_b, 0); chk("midrst od", od_b, 0); chk("midrst ir", ir_b, 1);
    q.delete();
    stalled = 0;
    for (int i = 0; i < 5; i++) step(0, 1);
    chk("post-rst silent", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
